calc2_port_responder: RTL and testbench
=======================================

CALC2_PORT_RESPONDER -- requirements
Module: calc2_port_responder

Interface
REQ-001 SHALL have port c_clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port req_cmd_in  input  4  command: 1=ADD, 2=SUB, 5=SHL, 6=SHR, 0=no request, other=invalid.
REQ-004 SHALL have port req_data_in  input  32  operand 1 on the command cycle, operand 2 on the following cycle.
REQ-005 SHALL have port req_tag_in  input  2  request tag, sampled with the command.
REQ-006 SHALL have port out_resp  output  2  0=none, 1=success, 2=overflow/underflow/invalid; 3 never driven.
REQ-007 SHALL have port out_data  output  32  result, valid only while out_resp!=0.
REQ-008 SHALL have port out_tag  output  2  tag of the request being answered.
REQ-009 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 SHALL have port drop_cnt  output  8  saturating count of dropped commands.

Function
REQ-011 SHALL implement FSM states IDLE, OPND2, EXEC1, EXEC2, RESP.
REQ-012 SHALL, in IDLE with req_cmd_in!=0 at edge E0, capture cmd, tag and operand 1, and go to OPND2.
REQ-013 SHALL, in OPND2 at edge E1, capture req_data_in as operand 2 unconditionally (req_cmd_in ignored, not counted) and go to EXEC1.
REQ-014 SHALL advance EXEC1->EXEC2 at E2 and EXEC2->RESP at E3, with out_resp/out_data/out_tag registered at E3.
REQ-015 SHALL hold the response for exactly one cycle (E3 to E4), then clear out_resp, out_data and out_tag to 0 at E4 unless a new response is produced.
REQ-016 SHALL, in RESP at E4, go to OPND2 and capture a new request if req_cmd_in!=0 (back-to-back), else go to IDLE.
REQ-017 SHALL, for req_cmd_in!=0 sampled in EXEC1 or EXEC2, drop the command and increment drop_cnt, saturating at 255.
REQ-018 SHALL compute ADD as the 33-bit sum; carry-out -> resp 2, data 0; else resp 1, data = sum[31:0].
REQ-019 SHALL compute SUB; operand 2 > operand 1 -> resp 2, data 0; else resp 1, data = difference.
REQ-020 SHALL compute SHL/SHR as logical shift of operand 1 by operand 2[4:0] (bits [31:5] ignored), always resp 1.
REQ-021 SHALL answer an invalid command with resp 2 and data 0 using the same timing (operand 2 cycle still consumed).
REQ-022 SHALL echo the captured tag on out_tag with every response, including error responses.
REQ-023 SHALL keep the captured operands and command stable from capture until E3, regardless of input activity.
REQ-024 SHALL have out_resp=0 and busy=0 in every cycle the FSM is in IDLE.

Reset
REQ-025 SHALL, on reset=0, immediately force state IDLE and out_resp, out_data, out_tag, busy and drop_cnt to 0, independent of c_clk.
REQ-026 SHALL, on reset asserted mid-operation, abandon the in-flight request with no response ever issued for it.
REQ-027 SHALL sample no command on the first rising edge at which reset is already deasserted unless req_cmd_in!=0 at that edge; inputs held at 0 produce no activity.

Verification
REQ-028 SHALL pass: ADD tag 1, 0x30 then 0x20 -> out_resp=1, out_data=0x50, out_tag=1, one cycle wide, 3 edges after operand 2.
REQ-029 SHALL pass: ADD 0xFFFFFFFF then 0x1 -> out_resp=2, out_data=0; SUB 0x5 then 0x6 -> out_resp=2, out_data=0; SUB 0x6 then 0x5 -> resp 1, data 0x1.
REQ-030 SHALL pass: SHL 0x1 by 0x23 (amount 3) -> resp 1, data 0x8; SHR 0x80000000 by 31 -> resp 1, data 0x1.
REQ-031 SHALL pass: invalid cmd 4'h3 tag 2 -> resp 2, data 0, tag 2 at normal latency.
REQ-032 SHALL pass: commands in EXEC1 and EXEC2 -> both dropped, drop_cnt=2; command at the RESP edge -> accepted back-to-back and answered correctly.
REQ-033 SHALL pass: reset=0 asserted in EXEC1 -> outputs 0 immediately, busy=0, no response after release; 300 drops -> drop_cnt=255.

Source files
------------

// File: rtl/calc2_port_responder.sv
// Two-operand request/response calculator port: takes a command plus two operands,
// answers three edges after the second operand with a one-cycle response pulse.
module calc2_port_responder (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  req_cmd_in,
  input  logic [31:0] req_data_in,
  input  logic [1:0]  req_tag_in,
  output logic [1:0]  out_resp,
  output logic [31:0] out_data,
  output logic [1:0]  out_tag,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

  // state | meaning
  // IDLE  | waiting for a command
  // OPND2 | command and operand 1 captured, operand 2 arrives this cycle
  // EXEC1 | first execute cycle, incoming commands are dropped
  // EXEC2 | second execute cycle, result registered on exit
  // RESP  | response on the outputs; a new command may be accepted
  typedef enum logic [2:0] {IDLE, OPND2, EXEC1, EXEC2, RESP} state_t;

  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_OK  = 2'd1;
  localparam logic [1:0] RESP_ERR = 2'd2;

  state_t      state, state_nxt;
  logic [3:0]  cmd_q;
  logic [1:0]  tag_q;
  logic [31:0] op1_q, op2_q;

  logic        cap_cmd;
  logic        drop_cmd;
  logic [32:0] sum_w;
  logic [1:0]  res_resp;
  logic [31:0] res_data;

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cap_cmd   = 1'b0;
    drop_cmd  = 1'b0;
    case (state)
      IDLE: begin
        if (req_cmd_in != 4'd0) begin
          cap_cmd   = 1'b1;
          state_nxt = OPND2;
        end
      end
      OPND2: state_nxt = EXEC1;
      EXEC1: begin
        drop_cmd  = (req_cmd_in != 4'd0);
        state_nxt = EXEC2;
      end
      EXEC2: begin
        drop_cmd  = (req_cmd_in != 4'd0);
        state_nxt = RESP;
      end
      RESP: begin
        if (req_cmd_in != 4'd0) begin
          cap_cmd   = 1'b1;
          state_nxt = OPND2;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sum_w    = {1'b0, op1_q} + {1'b0, op2_q};
    res_resp = RESP_ERR;
    res_data = 32'd0;
    case (cmd_q)
      CMD_ADD: begin
        if (!sum_w[32]) begin
          res_resp = RESP_OK;
          res_data = sum_w[31:0];
        end
      end
      CMD_SUB: begin
        if (op2_q <= op1_q) begin
          res_resp = RESP_OK;
          res_data = op1_q - op2_q;
        end
      end
      CMD_SHL: begin
        res_resp = RESP_OK;
        res_data = op1_q << op2_q[4:0];
      end
      CMD_SHR: begin
        res_resp = RESP_OK;
        res_data = op1_q >> op2_q[4:0];
      end
      default: begin
        res_resp = RESP_ERR;
        res_data = 32'd0;
      end
    endcase
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cmd_q    <= 4'd0;
      tag_q    <= 2'd0;
      op1_q    <= 32'd0;
      op2_q    <= 32'd0;
      out_resp <= 2'd0;
      out_data <= 32'd0;
      out_tag  <= 2'd0;
      drop_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      if (cap_cmd) begin
        cmd_q <= req_cmd_in;
        tag_q <= req_tag_in;
        op1_q <= req_data_in;
      end
      if (state == OPND2)
        op2_q <= req_data_in;
      // Response lives only in RESP; any other cycle clears it
      if (state == EXEC2) begin
        out_resp <= res_resp;
        out_data <= res_data;
        out_tag  <= tag_q;
      end else begin
        out_resp <= 2'd0;
        out_data <= 32'd0;
        out_tag  <= 2'd0;
      end
      if (drop_cmd && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_calc2_port_responder.sv
// Scoreboard bench for calc2_port_responder: directed requests push expected
// responses; a negedge monitor pops and compares whenever out_resp is nonzero.
module tb_calc2_port_responder;

  logic        c_clk;
  logic        reset;
  logic [3:0]  req_cmd_in;
  logic [31:0] req_data_in;
  logic [1:0]  req_tag_in;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic [1:0]  out_tag;
  logic        busy;
  logic [7:0]  drop_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    logic [1:0]  tag;
    int          at_cyc;
  } exp_t;

  exp_t sb[$];

  calc2_port_responder dut (
    .c_clk      (c_clk),
    .reset      (reset),
    .req_cmd_in (req_cmd_in),
    .req_data_in(req_data_in),
    .req_tag_in (req_tag_in),
    .out_resp   (out_resp),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  always @(posedge c_clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every nonzero response must match the oldest expectation, on time
  always @(negedge c_clk) begin
    exp_t e;
    if (out_resp != 2'd0) begin
      if (sb.size() == 0) begin
        checks   = checks + 1;
        failures = failures + 1;
        $display("FAIL unexpected_resp: got resp %0d data 0x%0h tag %0d expected none (cycle %0d)",
                 out_resp, out_data, out_tag, cyc);
      end else begin
        e = sb.pop_front();
        chk("resp", {30'd0, out_resp}, {30'd0, e.resp});
        chk("data", out_data, e.data);
        chk("tag", {30'd0, out_tag}, {30'd0, e.tag});
        chk("latency_cycle", cyc, e.at_cyc);
      end
    end else begin
      chk("idle_out_clear", {out_data[31:2], out_data[1:0] | out_tag}, 32'd0);
    end
  end

  // Presents a command now; returns #1 after the operand-2 edge (DUT in EXEC1)
  task automatic issue(input logic [3:0] cmd, input logic [1:0] tag,
                       input logic [31:0] op1, input logic [31:0] op2,
                       input logic [1:0] eresp, input logic [31:0] edata);
    exp_t e;
    req_cmd_in  = cmd;
    req_tag_in  = tag;
    req_data_in = op1;
    @(posedge c_clk); #1;
    req_cmd_in  = 4'd0;
    req_tag_in  = 2'd0;
    req_data_in = op2;
    @(posedge c_clk); #1;
    e.resp   = eresp;
    e.data   = edata;
    e.tag    = tag;
    e.at_cyc = cyc + 2;
    sb.push_back(e);
    req_data_in = 32'hDEAD_BEEF;
  endtask

  task automatic finish_req();
    req_cmd_in = 4'd0;
    repeat (3) begin
      @(posedge c_clk); #1;
    end
  endtask

  initial begin
    int waitc;
    reset       = 1'b0;
    req_cmd_in  = 4'd0;
    req_data_in = 32'd0;
    req_tag_in  = 2'd0;
    repeat (2) @(posedge c_clk);
    #1;
    chk("rst_resp", {30'd0, out_resp}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
    reset = 1'b1;
    repeat (3) begin
      @(posedge c_clk); #1;
    end
    chk("idle_no_activity_busy", {31'd0, busy}, 32'd0);

    issue(4'd1, 2'd1, 32'h30, 32'h20, 2'd1, 32'h50);
    chk("busy_exec", {31'd0, busy}, 32'd1);
    finish_req();
    chk("busy_after_resp", {31'd0, busy}, 32'd0);
    issue(4'd1, 2'd0, 32'hFFFF_FFFF, 32'h1, 2'd2, 32'h0);          finish_req();
    issue(4'd1, 2'd3, 32'h7FFF_FFFF, 32'h8000_0000, 2'd1, 32'hFFFF_FFFF); finish_req();
    issue(4'd2, 2'd3, 32'h5, 32'h6, 2'd2, 32'h0);                   finish_req();
    issue(4'd2, 2'd2, 32'h6, 32'h5, 2'd1, 32'h1);                   finish_req();
    issue(4'd2, 2'd1, 32'h7, 32'h7, 2'd1, 32'h0);                   finish_req();
    issue(4'd5, 2'd1, 32'h1, 32'h23, 2'd1, 32'h8);                  finish_req();
    issue(4'd6, 2'd0, 32'h8000_0000, 32'd31, 2'd1, 32'h1);          finish_req();
    issue(4'd3, 2'd2, 32'h1234, 32'h5678, 2'd2, 32'h0);             finish_req();

    // Commands in EXEC1/EXEC2 are dropped; one at the RESP edge is accepted
    issue(4'd1, 2'd0, 32'h10, 32'h5, 2'd1, 32'h15);
    req_cmd_in = 4'd1;
    @(posedge c_clk); #1;
    req_cmd_in = 4'd2;
    @(posedge c_clk); #1;
    chk("drop_cnt_two", {24'd0, drop_cnt}, 32'd2);
    issue(4'd2, 2'd3, 32'h100, 32'h1, 2'd1, 32'hFF);
    finish_req();
    chk("drop_cnt_hold", {24'd0, drop_cnt}, 32'd2);

    // Reset in EXEC1 abandons the request
    issue(4'd1, 2'd2, 32'h1, 32'h2, 2'd1, 32'h3);
    void'(sb.pop_back());
    #2 reset = 1'b0;
    #1;
    chk("midrst_resp", {30'd0, out_resp}, 32'd0);
    chk("midrst_data", out_data, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_drop", {24'd0, drop_cnt}, 32'd0);
    @(posedge c_clk); #1;
    reset = 1'b1;
    repeat (6) begin
      @(posedge c_clk); #1;
    end
    chk("midrst_idle", {31'd0, busy}, 32'd0);

    // Saturation: two drops per request, 150 requests
    for (int i = 0; i < 150; i++) begin
      issue(4'd1, i[1:0], 32'(i), 32'h1, 2'd1, 32'(i + 1));
      req_cmd_in = 4'd6;
      @(posedge c_clk); #1;
      @(posedge c_clk); #1;
      req_cmd_in = 4'd0;
      @(posedge c_clk); #1;
      if (i == 126) chk("drop_cnt_254", {24'd0, drop_cnt}, 32'd254);
    end
    chk("drop_cnt_sat", {24'd0, drop_cnt}, 32'd255);

    waitc = 0;
    while (sb.size() != 0 && waitc < 20) begin
      @(posedge c_clk); #1;
      waitc++;
    end
    chk("sb_drained", sb.size(), 32'd0);
    repeat (2) @(posedge c_clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
